// File: rtl/ofifo_col_pkg.sv
// rtl/ofifo_col_pkg.sv - shared constants and types for the output FIFO bank
package ofifo_col_pkg;
  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  typedef logic [PSUM_BW-1:0] psum_t;

  // One extra MSB on each pointer distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ofifo_col_fifo_col.sv
// rtl/ofifo_col_fifo_col.sv - single-column psum FIFO with combinational head word
module fifo_col
  import ofifo_col_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               pop,
  output logic [psum_bw-1:0] head,
  output logic               empty,
  output logic               full
);
  localparam int PW = ptr_w(depth);
  localparam int AW = PW - 1;

  logic [psum_bw-1:0] mem [depth];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic               push_acc;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A same-cycle pop frees the slot, so a full column still accepts the write.
  assign push_acc = wr && (!full || pop);
  assign head     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + PW'(1);
      if (pop)      rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ofifo_col.sv
// rtl/ofifo_col.sv - column-aligned output FIFO bank below the mac array
// Optional OFIFO_RELU_EN clamps negative psums to zero on the way into out.
module ofifo_col
  import ofifo_col_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_out_valid
);
  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col*psum_bw-1:0] head;
  logic [col*psum_bw-1:0] out_next;
  logic                   pop_acc;

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop_acc = rd && o_valid;

  for (genvar g = 0; g < col; g++) begin : g_col
    fifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .din   (in[g*psum_bw +: psum_bw]),
      .pop   (pop_acc),
      .head  (head[g*psum_bw +: psum_bw]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  always_comb begin
    out_next = head;
`ifdef OFIFO_RELU_EN
    for (int i = 0; i < col; i++) begin
      if (head[i*psum_bw + psum_bw - 1]) out_next[i*psum_bw +: psum_bw] = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out         <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= pop_acc;
      if (pop_acc) out <= out_next;
    end
  end
endmodule

// File: tb/tb_ofifo_col.sv
// tb/tb_ofifo_col.sv - directed self-checking bench for ofifo_col
module tb_ofifo_col;
  import ofifo_col_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out;
  logic         o_valid;
  logic         o_full;
  logic         o_ready;
  logic         o_out_valid;

  int vecs = 0;
  int errs = 0;

  ofifo_col dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .wr          (wr),
    .rd          (rd),
    .out         (out),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_ready     (o_ready),
    .o_out_valid (o_out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic psum_t rx(input psum_t v);
`ifdef OFIFO_RELU_EN
    return v[PSUM_BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [127:0] rep(input psum_t v);
    return {8{v}};
  endfunction

  logic [127:0] e;

  initial begin
    reset = 1'b1;
    in    = '0;
    wr    = '0;
    rd    = 1'b0;
    tick();
    tick();
    chk("rst_out", out, '0);
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_full", 128'(o_full), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_out_valid", 128'(o_out_valid), 128'(0));
    reset = 1'b0;
    tick();
    chk("idle_valid", 128'(o_valid), 128'(0));
    chk("idle_out_valid", 128'(o_out_valid), 128'(0));

    // skewed arrival, rd held high throughout
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = '0;
      in[i*16 +: 16] = 16'(100 + i);
      wr = 8'(1 << i);
      tick();
      chk($sformatf("skew_valid_%0d", i), 128'(o_valid), 128'(i == 7));
      chk($sformatf("skew_nopop_%0d", i), 128'(o_out_valid), 128'(0));
    end
    wr = '0;
    tick();
    for (int i = 0; i < 8; i++) e[i*16 +: 16] = rx(16'(100 + i));
    chk("skew_out", out, e);
    chk("skew_out_valid", 128'(o_out_valid), 128'(1));
    chk("skew_drained", 128'(o_valid), 128'(0));
    tick();
    chk("skew_pulse_end", 128'(o_out_valid), 128'(0));
    chk("skew_out_hold", out, e);
    rd = 1'b0;

    // reset mid-stream with 5 entries queued
    wr = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      in = rep(16'(k + 1));
      tick();
    end
    wr = '0;
    chk("q5_valid", 128'(o_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 128'(o_valid), 128'(0));
    chk("midrst_out", out, '0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_discard", 128'(o_valid), 128'(0));

    // fill every column to depth
    wr = 8'hFF;
    for (int k = 0; k < 64; k++) begin
      in = rep(16'(k));
      tick();
      if (k == 62) chk("fill63_full", 128'(o_full), 128'(0));
    end
    chk("fill64_full", 128'(o_full), 128'(1));
    chk("fill64_ready", 128'(o_ready), 128'(0));
    in = rep(16'h7777);
    tick();
    chk("drop_full", 128'(o_full), 128'(1));
    chk("drop_nopop", 128'(o_out_valid), 128'(0));

    // simultaneous push and pop on full columns
    in = rep(16'hABCD);
    rd = 1'b1;
    tick();
    wr = '0;
    chk("pp_out", out, rep(rx(16'd0)));
    chk("pp_out_valid", 128'(o_out_valid), 128'(1));
    chk("pp_still_full", 128'(o_full), 128'(1));
    for (int k = 1; k < 64; k++) begin
      tick();
      chk($sformatf("pop_%0d", k), out, rep(rx(16'(k))));
    end
    tick();
    chk("pop_last", out, rep(rx(16'hABCD)));
    chk("pop_last_valid", 128'(o_out_valid), 128'(1));
    chk("pop_empty", 128'(o_valid), 128'(0));
    tick();
    chk("rd_empty_ov", 128'(o_out_valid), 128'(0));
    chk("rd_empty_hold", out, rep(rx(16'hABCD)));
    rd = 1'b0;

    // column 3 empty while others hold data
    in = rep(16'h0055);
    wr = 8'hF7;
    tick();
    wr = '0;
    chk("c3_valid", 128'(o_valid), 128'(0));
    rd = 1'b1;
    tick();
    chk("c3_ov", 128'(o_out_valid), 128'(0));
    chk("c3_hold", out, rep(rx(16'hABCD)));
    rd = 1'b0;
    in = rep(16'h0033);
    wr = 8'h08;
    tick();
    wr = '0;
    chk("c3_filled", 128'(o_valid), 128'(1));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    e = rep(16'h0055);
    e[3*16 +: 16] = 16'h0033;
    chk("c3_aligned", out, e);
    chk("c3_drained", 128'(o_valid), 128'(0));

    // sign handling on the out path
    wr = 8'hFF;
    in = rep(16'hFFF0);
    tick();
    in = rep(16'h0010);
    tick();
    wr = '0;
    rd = 1'b1;
    tick();
    chk("relu_neg", out, rep(rx(16'hFFF0)));
    tick();
    chk("relu_pos", out, rep(16'h0010));
    rd = 1'b0;
    tick();
    chk("end_ov", 128'(o_out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
